// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the external memory port arbiter: FSM encoding and bus widths.
package mem_arbiter_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GNT_IC = 2'd1;
  localparam logic [1:0] ST_GNT_D  = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    GNT_IC = ST_GNT_IC,
    GNT_D  = ST_GNT_D
  } state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-way arbiter sharing the external memory port between I-cache refill and D-side.
// Grants are locked per transaction (full I burst or one D word); alternating priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BLOCK_WIDTH = 3
) (
  input  logic              i_ck,
  input  logic              i_rst,
  input  logic              i_ic_req,
  input  logic [ADDR_W-1:0] i_ic_addr,
  output logic              o_ic_ack,
  output logic [DATA_W-1:0] o_ic_data,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ack,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_data
);

  typedef logic [BLOCK_WIDTH-1:0] beat_t;

  state_t state_q;
  beat_t  beat_q;
  logic   prio_q;

  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      prio_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // prio_q = 0 favours the I-side when both request
          if (i_ic_req && (!i_d_req || !prio_q)) begin
            state_q <= GNT_IC;
          end else if (i_d_req) begin
            state_q <= GNT_D;
          end
        end
        GNT_IC: begin
          if (i_mem_ack) begin
            if (&beat_q) begin
              state_q <= IDLE;
              beat_q  <= '0;
              prio_q  <= 1'b1;
            end else begin
              beat_q <= beat_q + beat_t'(1);
            end
          end else if (!i_ic_req) begin
            // Abort leaves priority untouched
            state_q <= IDLE;
            beat_q  <= '0;
          end
        end
        GNT_D: begin
          if (i_mem_ack) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
          end else if (!i_d_req) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          beat_q  <= '0;
        end
      endcase
    end
  end

  // Grant-state forwarding is purely combinational to add no latency to the port.
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_ic_ack    = 1'b0;
    o_d_ack     = 1'b0;
    case (state_q)
      GNT_IC: begin
        o_mem_req  = i_ic_req;
        o_mem_addr = i_ic_addr;
        o_ic_ack   = i_mem_ack;
      end
      GNT_D: begin
        o_mem_req   = i_d_req;
        o_mem_we    = i_d_we;
        o_mem_addr  = i_d_addr;
        o_mem_wdata = i_d_wdata;
        o_d_ack     = i_mem_ack;
      end
      default: begin
        o_mem_req = 1'b0;
      end
    endcase
  end

  assign o_ic_data = i_mem_data;
  assign o_d_rdata = i_mem_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  logic        i_ck = 1'b0;
  logic        i_rst;
  logic        i_ic_req;
  logic [29:0] i_ic_addr;
  logic        o_ic_ack;
  logic [31:0] o_ic_data;
  logic        i_d_req;
  logic        i_d_we;
  logic [29:0] i_d_addr;
  logic [31:0] i_d_wdata;
  logic        o_d_ack;
  logic [31:0] o_d_rdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [29:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_data;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.BLOCK_WIDTH(3)) dut (
    .i_ck(i_ck), .i_rst(i_rst),
    .i_ic_req(i_ic_req), .i_ic_addr(i_ic_addr), .o_ic_ack(o_ic_ack), .o_ic_data(o_ic_data),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .o_d_ack(o_d_ack), .o_d_rdata(o_d_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data)
  );

  always #5 i_ck = ~i_ck;

  // Advance past the next rising edge; inputs are then changed and checked mid-cycle.
  task automatic tick();
    @(posedge i_ck);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_ic_req = 0; i_ic_addr = 0; i_d_req = 0; i_d_we = 0;
    i_d_addr = 0; i_d_wdata = 0; i_mem_ack = 0; i_mem_data = 0;
    tick(); tick();
    #1;
    n_cmp++; if (o_mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", o_mem_req); end
    n_cmp++; if (o_mem_addr !== 30'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", o_mem_addr); end
    n_cmp++; if (o_ic_ack !== 1'b0 || o_d_ack !== 1'b0) begin n_err++; $display("FAIL rst_acks: got %b%b want 00", o_ic_ack, o_d_ack); end
    i_rst = 1'b0;
    i_ic_req = 1'b1; i_ic_addr = 30'h080;
    tick();
    #1;
    n_cmp++; if (o_mem_req !== 1'b1 || o_mem_addr !== 30'h080) begin n_err++; $display("FAIL rst_pre_grant: got req=%b addr=%h want 1/080", o_mem_req, o_mem_addr); end
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0; i_ic_addr = 30'h081; i_rst = 1'b1;
    tick();
    #1;
    n_cmp++; if (o_mem_req !== 1'b0 || o_mem_addr !== 30'h0) begin n_err++; $display("FAIL rst_midburst: got req=%b addr=%h want 0/0", o_mem_req, o_mem_addr); end
    tick();
    i_rst = 1'b0; i_ic_addr = 30'h090; i_d_req = 1'b1; i_d_addr = 30'h010;
    #1;
    n_cmp++; if (o_mem_req !== 1'b0) begin n_err++; $display("FAIL rst_idle_after: got %b want 0", o_mem_req); end
    tick();
    #1;
    n_cmp++; if (o_mem_req !== 1'b1 || o_mem_addr !== 30'h090 || o_mem_we !== 1'b0) begin n_err++; $display("FAIL rst_ic_prio: got req=%b addr=%h we=%b want 1/090/0", o_mem_req, o_mem_addr, o_mem_we); end
    i_ic_req = 1'b0; i_d_req = 1'b0;
    tick();
  endtask

  task automatic test_lone_ic();
    i_ic_req = 1'b1; i_ic_addr = 30'h100;
    #1;
    n_cmp++; if (o_mem_req !== 1'b0) begin n_err++; $display("FAIL lone_latency: got %b want 0", o_mem_req); end
    tick();
    for (int k = 0; k < 8; k++) begin
      i_ic_addr = 30'h100 + 30'(k); i_mem_ack = 1'b1; i_mem_data = 32'hA000_0000 + 32'(k);
      #1;
      n_cmp++; if (o_ic_ack !== 1'b1 || o_d_ack !== 1'b0) begin n_err++; $display("FAIL lone_ack%0d: got ic=%b d=%b want 1/0", k, o_ic_ack, o_d_ack); end
      n_cmp++; if (o_mem_addr !== 30'h100 + 30'(k) || o_ic_data !== 32'hA000_0000 + 32'(k)) begin n_err++; $display("FAIL lone_addr%0d: got addr=%h data=%h", k, o_mem_addr, o_ic_data); end
      tick();
    end
    // Stray ack while holding the address: only a state still in GNT_IC would forward it
    i_ic_req = 1'b0; i_ic_addr = 30'h108;
    #1;
    n_cmp++; if (o_ic_ack !== 1'b0 || o_mem_addr !== 30'h0) begin n_err++; $display("FAIL lone_idle: got ack=%b addr=%h want 0/0", o_ic_ack, o_mem_addr); end
    i_mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    i_ic_req = 1'b1; i_ic_addr = 30'h200;
    i_d_req = 1'b1; i_d_we = 1'b1; i_d_addr = 30'h020; i_d_wdata = 32'hDEADBEEF;
    tick();
    #1;
    n_cmp++; if (o_mem_addr !== 30'h200 || o_mem_we !== 1'b0 || o_mem_wdata !== 32'h0) begin n_err++; $display("FAIL sim_ic_first: got addr=%h we=%b wd=%h want 200/0/0", o_mem_addr, o_mem_we, o_mem_wdata); end
    for (int k = 0; k < 8; k++) begin
      i_ic_addr = 30'h200 + 30'(k); i_mem_ack = 1'b1;
      #1;
      n_cmp++; if (o_ic_ack !== 1'b1 || o_d_ack !== 1'b0) begin n_err++; $display("FAIL sim_ic_ack%0d: got ic=%b d=%b want 1/0", k, o_ic_ack, o_d_ack); end
      tick();
    end
    i_ic_req = 1'b0; i_mem_ack = 1'b0;
    #1;
    n_cmp++; if (o_mem_req !== 1'b0) begin n_err++; $display("FAIL sim_gap: got %b want 0", o_mem_req); end
    tick();
    n_cmp++; if (o_mem_req !== 1'b1 || o_mem_we !== 1'b1 || o_mem_addr !== 30'h020 || o_mem_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL sim_d_write: got req=%b we=%b addr=%h wd=%h", o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata); end
    i_mem_ack = 1'b1; i_mem_data = 32'h0000_1234;
    #1;
    n_cmp++; if (o_d_ack !== 1'b1 || o_ic_ack !== 1'b0 || o_d_rdata !== 32'h0000_1234) begin n_err++; $display("FAIL sim_d_ack: got d=%b ic=%b rd=%h", o_d_ack, o_ic_ack, o_d_rdata); end
    tick();
    i_d_req = 1'b0; i_d_we = 1'b0; i_mem_ack = 1'b0;
    #1;
    n_cmp++; if (o_mem_req !== 1'b0) begin n_err++; $display("FAIL sim_end: got %b want 0", o_mem_req); end
    tick();
  endtask

  task automatic test_back_to_back();
    i_ic_req = 1'b1; i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 30'h040; i_d_wdata = 0;
    i_ic_addr = 30'h300;
    tick();
    for (int t = 0; t < 4; t++) begin
      if ((t % 2) == 0) begin
        for (int k = 0; k < 8; k++) begin
          i_ic_addr = 30'h300 + 30'(8 * t + k); i_mem_ack = 1'b1;
          #1;
          n_cmp++; if (o_ic_ack !== 1'b1 || o_mem_addr !== 30'h300 + 30'(8 * t + k)) begin n_err++; $display("FAIL b2b_t%0d_ic%0d: got ack=%b addr=%h", t, k, o_ic_ack, o_mem_addr); end
          tick();
        end
      end else begin
        i_mem_ack = 1'b1;
        #1;
        n_cmp++; if (o_d_ack !== 1'b1 || o_mem_addr !== 30'h040) begin n_err++; $display("FAIL b2b_t%0d_d: got ack=%b addr=%h want 1/040", t, o_d_ack, o_mem_addr); end
        tick();
      end
      i_mem_ack = 1'b0; i_ic_addr = 30'h300 + 30'(8 * (t + 1));
      #1;
      n_cmp++; if (o_mem_req !== 1'b0) begin n_err++; $display("FAIL b2b_gap%0d: got %b want 0", t, o_mem_req); end
      if (t < 3) tick();
    end
    i_ic_req = 1'b0; i_d_req = 1'b0;
    tick();
  endtask

  task automatic test_stray_abort();
    i_mem_ack = 1'b1; i_mem_data = 32'h5555_AAAA;
    #1;
    n_cmp++; if (o_ic_ack !== 1'b0 || o_d_ack !== 1'b0) begin n_err++; $display("FAIL stray_idle: got ic=%b d=%b want 0/0", o_ic_ack, o_d_ack); end
    tick();
    i_mem_ack = 1'b0; i_ic_req = 1'b1; i_ic_addr = 30'h500;
    tick();
    for (int k = 0; k < 3; k++) begin
      i_ic_addr = 30'h500 + 30'(k); i_mem_ack = 1'b1;
      tick();
    end
    i_ic_req = 1'b0; i_mem_ack = 1'b0;
    tick();
    i_mem_ack = 1'b1;
    #1;
    n_cmp++; if (o_ic_ack !== 1'b0 || o_mem_req !== 1'b0) begin n_err++; $display("FAIL abort_idle: got ack=%b req=%b want 0/0", o_ic_ack, o_mem_req); end
    // Both request after the abort: priority must still favour the I-side
    i_mem_ack = 1'b0; i_ic_req = 1'b1; i_ic_addr = 30'h600; i_d_req = 1'b1; i_d_addr = 30'h070;
    tick();
    for (int k = 0; k < 8; k++) begin
      i_ic_addr = 30'h600 + 30'(k); i_mem_ack = 1'b1;
      #1;
      n_cmp++; if (o_ic_ack !== 1'b1 || o_mem_addr !== 30'h600 + 30'(k)) begin n_err++; $display("FAIL abort_reburst%0d: got ack=%b addr=%h", k, o_ic_ack, o_mem_addr); end
      tick();
    end
    i_ic_req = 1'b0; i_mem_ack = 1'b0;
    tick();
    n_cmp++; if (o_mem_req !== 1'b1 || o_mem_addr !== 30'h070) begin n_err++; $display("FAIL abort_then_d: got req=%b addr=%h want 1/070", o_mem_req, o_mem_addr); end
    i_mem_ack = 1'b1;
    tick();
    i_d_req = 1'b0; i_mem_ack = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_lone_ic();
    test_simultaneous();
    test_back_to_back();
    test_stray_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
